// File: rtl/regfile_param.sv
// Two-read / one-write register file with registered read data, same-cycle write bypass,
// and a self-clearing start-up walk that zeroes every entry before the ports go live.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_addr_eff;
  logic              wr_fire;
  logic [DATA_W-1:0] rd_word1, rd_word2;

  // An address is "live" when it maps to a real, writable entry; the hard-wired
  // zero entry and out-of-range addresses both read as 0 and swallow writes.
  function automatic logic live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_A) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
    if (!live(a))
      return '0;
    else if (wr_fire && (wr_addr_eff == a))
      return wr_data;
    else
      return mem[idx(a)];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR)
        ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if ((state == CLEAR) && (ptr == PTR_LAST))
      state_nx = READY;
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  assign wr_addr_eff = wr_sel ? rd_addr2 : wr_addr;
  assign wr_fire     = !rst && (state == READY) && wr_en && live(wr_addr_eff);
  assign rd_word1    = read_word(rd_addr1);
  assign rd_word2    = read_word(rd_addr2);

  always_ff @(posedge clk) begin
    if (!rst && (state == CLEAR))
      mem[ptr] <= '0;
    else if (wr_fire)
      mem[idx(wr_addr_eff)] <= wr_data;
  end

  // Read stage: registered outputs, forced to 0 while the array is not yet valid.
  always_ff @(posedge clk) begin
    if (rst || (state == CLEAR)) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      if (rd_en1)
        rd_data1 <= rd_word1;
      if (rd_en2)
        rd_data2 <= rd_word2;
    end
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits.
REQ-002 Parameter DEPTH, default 16, number of entries (2..2**ADDR_W).
REQ-003 Parameter ADDR_W, default 5, address width of all address ports.
REQ-004 Parameter ZERO_REG, default 0, when 1 entry 0 SHALL read as 0 and ignore writes.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rd_en1  input  1  read-port-1 enable.
REQ-008 rd_en2  input  1  read-port-2 enable.
REQ-009 rd_addr1  input  ADDR_W  read-port-1 address.
REQ-010 rd_addr2  input  ADDR_W  read-port-2 address.
REQ-011 rd_data1  output  DATA_W  registered read-port-1 data.
REQ-012 rd_data2  output  DATA_W  registered read-port-2 data.
REQ-013 wr_en  input  1  write enable.
REQ-014 wr_sel  input  1  destination select: 0 = wr_addr, 1 = rd_addr2.
REQ-015 wr_addr  input  ADDR_W  write address when wr_sel=0.
REQ-016 wr_data  input  DATA_W  write data.
REQ-017 busy  output  1  high while the clear sequence runs; ports ignored.

Function
REQ-018 Two-state FSM, CLEAR and READY; rst forces CLEAR with clear pointer = 0.
REQ-019 In CLEAR with rst low, entry[ptr] SHALL be written 0 each cycle, ptr+1; at ptr = DEPTH-1 the FSM SHALL enter READY next cycle.
REQ-020 Clear sequence: exactly DEPTH cycles from first cycle with rst low to busy low.
REQ-021 busy SHALL equal 1 in CLEAR, 0 in READY, as a registered output.
REQ-022 In CLEAR, wr_en, rd_en1, rd_en2 SHALL be ignored and rd_data1/rd_data2 held at 0.
REQ-023 In READY, rd_enN=1 SHALL load rd_dataN with entry[rd_addrN] at the next edge (1-cycle latency).
REQ-024 In READY, rd_enN=0 SHALL hold rd_dataN unchanged.
REQ-025 Effective write address = wr_sel ? rd_addr2 : wr_addr; write occurs at edge when wr_en=1 in READY.
REQ-026 Bypass: read and write to same effective address in the same cycle SHALL return wr_data (new data).
REQ-027 Address >= DEPTH: read SHALL return 0, write SHALL be dropped, no other entry disturbed.
REQ-028 ZERO_REG=1: reads of address 0 SHALL return 0 including bypass case; writes to 0 dropped; clear still walks entry 0.
REQ-029 Both read ports SHALL operate independently and may read the same address concurrently.
REQ-030 rst asserted mid-clear or mid-operation SHALL restart the clear sequence from ptr 0.

Reset
REQ-031 While rst=1: busy=1, rd_data1=0, rd_data2=0, FSM=CLEAR, ptr=0, all outputs defined from the first edge.
REQ-032 Array contents SHALL be all-zero only after the clear sequence completes; no reliance on initial blocks.

Verification
REQ-033 rst 1 cycle, DEPTH=16 -> busy high 16 cycles after rst falls, then 0; rd_en1 pulses during busy -> rd_data1 stays 0.
REQ-034 After clear: write 0x12 to addr 1, 0x2 to addr 15; read sr1=1, sr2=15 -> rd_data1=0x12, rd_data2=0x2 one cycle later.
REQ-035 Same cycle wr_en addr 3 data 0xA5A5A5A5 with rd_en1 addr 3 -> rd_data1=0xA5A5A5A5 next edge.
REQ-036 wr_sel=1, rd_addr2=7, wr_addr=4, data 0x55 -> entry 7=0x55, entry 4 unchanged (0).
REQ-037 Write addr 20 (DEPTH=16) data 0xFF, then read addr 20 and addr 4 -> both return 0.
REQ-038 ZERO_REG=1: write 0x99 to addr 0 with concurrent read addr 0 -> rd_data=0; rst asserted mid-clear at ptr 8 -> busy stays high 16 further cycles.
